// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package fetch_pkg;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned PC_STEP     = 4;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

    // One IF/ID entry; pc is the address of the instruction plus PC_STEP.
    typedef struct packed {
        logic                   valid;
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instruction;
    } if_id_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register that catches the single response landing
// after the decode side freezes. Clear beats load, load beats drain.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   drain_i,
    input  logic   clear_i,
    input  if_id_t data_i,
    output if_id_t data_o,
    output logic   full_o
);
    logic   full_q, full_d;
    if_id_t data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

    // Issue stops while frozen, so a second word can never land on a full entry.
    skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(load_i && full_q && !clear_i));
endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and IF/ID register for a registered-output instruction memory.
// Define FETCH_PERF_CNT_EN to add fetched_count / stall_count counters.
module instr_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = fetch_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = fetch_pkg::RESET_PC,
    parameter int unsigned           PC_STEP    = fetch_pkg::PC_STEP
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [31:0]           imem_instruction,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_address,
    output logic                  if_valid,
    output logic [31:0]           if_instruction,
    output logic [ADDR_WIDTH-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetched_count,
    output logic [31:0]           stall_count
`endif
);
    import fetch_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
    logic                  resp_valid_q, resp_valid_d;
    if_id_t                ifid_q, ifid_d, resp_entry, skid_entry;
    logic                  skid_full, skid_load, skid_drain;

    assign resp_entry = '{valid: 1'b1, pc: resp_pc_q + STEP, instruction: imem_instruction};
    assign skid_load  = freeze && !branch_taken && resp_valid_q;
    assign skid_drain = !freeze && !branch_taken && skid_full;

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (branch_taken),
        .data_i  (resp_entry),
        .data_o  (skid_entry),
        .full_o  (skid_full)
    );

    // Redirect beats freeze: it squashes the in-flight word and empties IF/ID.
    always_comb begin
        pc_d         = pc_q;
        resp_valid_d = 1'b0;
        resp_pc_d    = resp_pc_q;
        ifid_d       = ifid_q;
        if (branch_taken) begin
            pc_d         = branch_address;
            ifid_d.valid = 1'b0;
        end else if (!freeze) begin
            pc_d         = pc_q + STEP;
            resp_valid_d = 1'b1;
            resp_pc_d    = pc_q;
            if (skid_full)
                ifid_d = skid_entry;
            else if (resp_valid_q)
                ifid_d = resp_entry;
            else
                ifid_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
            ifid_q       <= '0;
        end else begin
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            ifid_q       <= ifid_d;
        end
    end

    assign imem_address   = pc_q;
    assign if_valid       = ifid_q.valid;
    assign if_pc          = ifid_q.pc;
    assign if_instruction = ifid_q.instruction;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, stall_q;
    logic        load_valid;

    assign load_valid = !branch_taken && !freeze && (skid_full || resp_valid_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (load_valid && (fetched_q != '1))
                fetched_q <= fetched_q + 32'd1;
            if (freeze && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign fetched_count = fetched_q;
    assign stall_count   = stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit; FETCH_PERF_CNT_EN also checks counters.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction = '0;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_count, stall_count;
    int          exp_fetched = 0;
    int          exp_stall = 0;
`endif

    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] ins;
        bit          chk;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   row = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .freeze           (freeze),
        .branch_taken     (branch_taken),
        .branch_address   (branch_address),
        .if_valid         (if_valid),
        .if_instruction   (if_instruction),
        .if_pc            (if_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetched_count    (fetched_count),
        .stall_count      (stall_count)
`endif
    );

    // Registered memory returning address-tagged words.
    always @(posedge clk) imem_instruction <= 32'hA000_0000 | imem_address;

    // Monitor: each edge following a pushed vector presents one expected state.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (if_valid !== e.v) begin
                errors++;
                $display("FAIL row%0d if_valid got %0b want %0b", e.id, if_valid, e.v);
            end
            if (e.chk) begin
                checks++;
                if (if_pc !== e.pc) begin
                    errors++;
                    $display("FAIL row%0d if_pc got %h want %h", e.id, if_pc, e.pc);
                end
                checks++;
                if (if_instruction !== e.ins) begin
                    errors++;
                    $display("FAIL row%0d if_instruction got %h want %h", e.id, if_instruction, e.ins);
                end
            end
        end
    end

    task automatic step(input bit r, input bit f, input bit b, input logic [31:0] ba,
                        input bit ev, input logic [31:0] epc, input logic [31:0] ei,
                        input bit chk);
        exp_t e;
        @(negedge clk);
        rst = r;
        freeze = f;
        branch_taken = b;
        branch_address = ba;
        e.v = ev; e.pc = epc; e.ins = ei; e.chk = chk; e.id = row;
        exp_q.push_back(e);
        row++;
`ifdef FETCH_PERF_CNT_EN
        if (r) begin
            exp_fetched = 0;
            exp_stall = 0;
        end else begin
            if (f) exp_stall++;
            if (!f && !b && ev) exp_fetched++;
        end
`endif
    endtask

    initial begin
        //   rst frz br  baddr         ev  pc            instr         chk
        step(1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1); // 0 reset
        step(1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1);
        step(0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1); // 2 first issue
        step(0, 0, 0, 32'h0,         1, 32'h4,         32'hA000_0000, 1);
        step(0, 0, 0, 32'h0,         1, 32'h8,         32'hA000_0004, 1);
        step(0, 1, 0, 32'h0,         1, 32'h8,         32'hA000_0004, 1); // 5 freeze x3
        step(0, 1, 0, 32'h0,         1, 32'h8,         32'hA000_0004, 1);
        step(0, 1, 0, 32'h0,         1, 32'h8,         32'hA000_0004, 1);
        step(0, 0, 0, 32'h0,         1, 32'hC,         32'hA000_0008, 1); // 8 skid drains
        step(0, 0, 0, 32'h0,         1, 32'h10,        32'hA000_000C, 1);
        step(0, 0, 1, 32'h40,        0, 32'h0,         32'h0,         0); // 10 redirect, 0x10 in flight
        step(0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         0);
        step(0, 0, 0, 32'h0,         1, 32'h44,        32'hA000_0040, 1);
        step(0, 0, 0, 32'h0,         1, 32'h48,        32'hA000_0044, 1);
        step(0, 1, 1, 32'h80,        0, 32'h0,         32'h0,         0); // 14 redirect + freeze
        step(0, 1, 0, 32'h0,         0, 32'h0,         32'h0,         0);
        step(0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         0);
        step(0, 0, 0, 32'h0,         1, 32'h84,        32'hA000_0080, 1);
        step(0, 0, 0, 32'h0,         1, 32'h88,        32'hA000_0084, 1);
        step(0, 1, 0, 32'h0,         1, 32'h88,        32'hA000_0084, 1); // 19 skid fills
        step(1, 1, 0, 32'h0,         0, 32'h0,         32'h0,         1); // 20 reset mid-freeze
        step(0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1);
        step(0, 0, 0, 32'h0,         1, 32'h4,         32'hA000_0000, 1);
        step(0, 0, 0, 32'h0,         1, 32'h8,         32'hA000_0004, 1);
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0); // 24 redirect to top
        step(0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         0);
        step(0, 0, 0, 32'h0,         1, 32'h0,         32'hFFFF_FFFC, 1); // pc wraps
        step(0, 0, 0, 32'h0,         1, 32'h4,         32'hA000_0000, 1);
        step(0, 1, 0, 32'h0,         1, 32'h4,         32'hA000_0000, 1); // 28 freeze x3
        step(0, 1, 0, 32'h0,         1, 32'h4,         32'hA000_0000, 1);
        step(0, 1, 0, 32'h0,         1, 32'h4,         32'hA000_0000, 1);
        step(0, 0, 0, 32'h0,         1, 32'h8,         32'hA000_0004, 1);
        step(0, 0, 0, 32'h0,         1, 32'hC,         32'hA000_0008, 1);
        @(posedge clk);
        #2;
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (stall_count !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL stall_count got %0d want %0d", stall_count, exp_stall);
        end
        checks++;
        if (fetched_count !== 32'(exp_fetched)) begin
            errors++;
            $display("FAIL fetched_count got %0d want %0d", fetched_count, exp_fetched);
        end
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
